// File: rtl/regfile_pkg.sv
// Shared constants for the 32x32 register file and the FSM state
// encoding of its sequential read-side master.
package regfile_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FETCH  = 3'd1;
  localparam state_t ST_EMIT_A = 3'd2;
  localparam state_t ST_EMIT_B = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

endpackage

// File: rtl/regfile_reader_if.sv
// Bus bundle of the register dump master: the two register file read
// ports plus the outgoing beat stream.
//
// Stream handshake: a beat transfers on a rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// out_reg and out_data hold steady and out_valid stays up; only abort or
// reset may drop it without a transfer. out_valid never depends on
// out_ready.
interface regfile_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] read_reg_1;
  logic [ADDR_W-1:0] read_reg_2;
  logic [DATA_W-1:0] read_data_1;
  logic [DATA_W-1:0] read_data_2;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_reg;
  logic [DATA_W-1:0] out_data;

  modport master (
    output read_reg_1, read_reg_2,
    input  read_data_1, read_data_2,
    output out_valid, out_reg, out_data,
    input  out_ready
  );

  modport slave (
    input  read_reg_1, read_reg_2,
    output read_data_1, read_data_2,
    input  out_valid, out_reg, out_data,
    output out_ready
  );
endinterface

// File: rtl/regfile_reader.sv
// Sequential read-side master for the register file. Walks [lo, hi]
// two indices per fetch, snapshots each pair, then emits one register
// per beat on the stream. Never writes the register file.
module regfile_reader
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] range_lo,
  input  logic [ADDR_W-1:0] range_hi,
  regfile_reader_if.master  bus,
  output logic              busy,
  output logic              done,
  output state_t            dbg_state
);

  localparam logic [ADDR_W:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0] PTR_TWO = 2;

  state_t state_q, state_d;

  // ptr is one bit wider than an index so ptr+1/ptr+2 never wrap when
  // compared against hi; lo only seeds ptr and needs no register of its own.
  logic [ADDR_W:0]   ptr_q;
  logic [ADDR_W-1:0] hi_q;
  logic [DATA_W-1:0] buf_a, buf_b;
  logic [ADDR_W-1:0] last_reg;
  logic [DATA_W-1:0] last_data;

  logic [ADDR_W:0] ptr_p1, ptr_p2, hi_ext;

  assign ptr_p1    = ptr_q + PTR_ONE;
  assign ptr_p2    = ptr_q + PTR_TWO;
  assign hi_ext    = {1'b0, hi_q};
  assign dbg_state = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Pointer, range latch, snapshot buffers and the held beat fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      hi_q      <= '0;
      buf_a     <= '0;
      buf_b     <= '0;
      last_reg  <= '0;
      last_data <= '0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        hi_q  <= range_hi;
        ptr_q <= {1'b0, range_lo};
      end
      if (state_q == ST_FETCH) begin
        buf_a <= bus.read_data_1;
        buf_b <= bus.read_data_2;
      end
      if (state_q == ST_EMIT_B && bus.out_ready && !abort) ptr_q <= ptr_p2;
      if (bus.out_valid) begin
        last_reg  <= bus.out_reg;
        last_data <= bus.out_data;
      end
    end
  end

  // Next-state logic; abort overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = (range_lo > range_hi) ? ST_DONE : ST_FETCH;
      ST_FETCH:  state_d = ST_EMIT_A;
      ST_EMIT_A: if (bus.out_ready) state_d = (ptr_p1 <= hi_ext) ? ST_EMIT_B : ST_DONE;
      ST_EMIT_B: if (bus.out_ready) state_d = (ptr_p2 <= hi_ext) ? ST_FETCH : ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
  end

  // Outputs decoded from the current state; beat fields hold when idle.
  always_comb begin
    bus.read_reg_1 = '0;
    bus.read_reg_2 = '0;
    bus.out_valid  = 1'b0;
    bus.out_reg    = last_reg;
    bus.out_data   = last_data;
    busy           = (state_q != ST_IDLE);
    done           = (state_q == ST_DONE);
    case (state_q)
      ST_FETCH: begin
        bus.read_reg_1 = ptr_q[ADDR_W-1:0];
        bus.read_reg_2 = ptr_p1[ADDR_W-1:0];
      end
      ST_EMIT_A: begin
        bus.out_valid = 1'b1;
        bus.out_reg   = ptr_q[ADDR_W-1:0];
        bus.out_data  = buf_a;
      end
      ST_EMIT_B: begin
        bus.out_valid = 1'b1;
        bus.out_reg   = ptr_p1[ADDR_W-1:0];
        bus.out_data  = buf_b;
      end
      default: ;
    endcase
  end

endmodule
